// File: rtl/bp_cfg_loader_pkg.sv
`default_nettype none
// -------------------------------------------------------------------------
// bp_cfg_loader_pkg: shared types for the config loader.          Rev 1.0
// -------------------------------------------------------------------------
package bp_cfg_loader_pkg;

   typedef struct packed {
      logic [31:0] cfg_core_width;
      logic [31:0] cfg_addr_width;
      logic [31:0] cfg_data_width;
   } bp_proc_param_s;

   localparam bp_proc_param_s BP_CFG_PROC_PARAM = '{
      cfg_core_width: 32'd8,
      cfg_addr_width: 32'd16,
      cfg_data_width: 32'd64
   };

   localparam int CFG_CORE_WIDTH = int'(BP_CFG_PROC_PARAM.cfg_core_width);
   localparam int CFG_ADDR_WIDTH = int'(BP_CFG_PROC_PARAM.cfg_addr_width);
   localparam int CFG_DATA_WIDTH = int'(BP_CFG_PROC_PARAM.cfg_data_width);

   typedef struct packed {
      logic [CFG_CORE_WIDTH-1:0] core;
      logic [CFG_ADDR_WIDTH-1:0] addr;
      logic [CFG_DATA_WIDTH-1:0] data;
   } bp_cfg_write_s;

   typedef struct packed {
      logic [CFG_ADDR_WIDTH-1:0] addr;
      logic [CFG_DATA_WIDTH-1:0] data;
   } bp_cfg_entry_s;

   typedef enum logic [2:0] {
      e_idle  = 3'd0,
      e_fetch = 3'd1,
      e_wait  = 3'd2,
      e_send  = 3'd3,
      e_done  = 3'd4
   } bp_cfg_state_e;

   // Index width for a bound of n, never narrower than one bit.
   function automatic int bp_cfg_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cfg_loader_counter.sv
`default_nettype none
// -------------------------------------------------------------------------
// bp_cfg_loader_counter: wrapping up-counter, 0..max_val_p-1.      Rev 1.0
// -------------------------------------------------------------------------
module bp_cfg_loader_counter
   import bp_cfg_loader_pkg::*;
#(
   parameter int max_val_p = 2
) (
   input  logic                                    clk_i,
   input  logic                                    reset_i,
   input  logic                                    clear_i,
   input  logic                                    en_i,
   output logic [bp_cfg_idx_width(max_val_p)-1:0]  count_o,
   output logic                                    last_o
);

   localparam int WIDTH = bp_cfg_idx_width(max_val_p);

   assign last_o = (count_o == WIDTH'(max_val_p - 1));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_o <= '0;
      end else if (clear_i) begin
         count_o <= '0;
      end else if (en_i) begin
         count_o <= last_o ? '0 : count_o + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/bp_cfg_loader.sv
`default_nettype none
// -------------------------------------------------------------------------
// bp_cfg_loader: streams ROM config entries to every core.         Rev 1.0
// -------------------------------------------------------------------------
module bp_cfg_loader
   import bp_cfg_loader_pkg::*;
#(
   parameter int num_core_p       = 1,
   parameter int num_entries_p    = 16,
   parameter int cfg_core_width_p = CFG_CORE_WIDTH,
   parameter int cfg_addr_width_p = CFG_ADDR_WIDTH,
   parameter int cfg_data_width_p = CFG_DATA_WIDTH
) (
   input  logic                                          clk_i,
   input  logic                                          reset_i,
   input  logic                                          start_i,
   output logic                                          rom_v_o,
   output logic [bp_cfg_idx_width(num_entries_p)-1:0]    rom_idx_o,
   input  logic [cfg_addr_width_p+cfg_data_width_p-1:0]  rom_data_i,
   output logic                                          cfg_v_o,
   output logic [cfg_core_width_p-1:0]                   cfg_core_o,
   output logic [cfg_addr_width_p-1:0]                   cfg_addr_o,
   output logic [cfg_data_width_p-1:0]                   cfg_data_o,
   input  logic                                          cfg_ready_i,
   output logic                                          busy_o,
   output logic                                          done_o
);

   localparam int ENTRY_W = bp_cfg_idx_width(num_entries_p);
   localparam int CORE_W  = bp_cfg_idx_width(num_core_p);

   bp_cfg_state_e        state;
   bp_cfg_state_e        state_n;
   logic [ENTRY_W-1:0]   entry_cnt;
   logic [CORE_W-1:0]    core_cnt;
   logic                 entry_last;
   logic                 core_last;
   logic                 clear_cnt;
   logic                 handshake;
   logic                 done_r;
   bp_cfg_entry_s        send_buf;
   bp_cfg_write_s        cfg_pkt;

   assign handshake = (state == e_send) && cfg_ready_i;

   bp_cfg_loader_counter #(
      .max_val_p (num_entries_p)
   ) entry_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (clear_cnt),
      .en_i    (handshake),
      .count_o (entry_cnt),
      .last_o  (entry_last)
   );

   // The core index only advances when the entry index wraps.
   bp_cfg_loader_counter #(
      .max_val_p (num_core_p)
   ) core_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (clear_cnt),
      .en_i    (handshake && entry_last),
      .count_o (core_cnt),
      .last_o  (core_last)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= e_idle;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      clear_cnt = 1'b0;
      case (state)
         e_idle: begin
            if (start_i) begin
               clear_cnt = 1'b1;
               state_n   = e_fetch;
            end
         end
         e_fetch: state_n = e_wait;
         e_wait:  state_n = e_send;
         e_send: begin
            if (handshake) begin
               state_n = (entry_last && core_last) ? e_done : e_fetch;
            end
         end
         e_done:  state_n = e_idle;
         default: state_n = e_idle;
      endcase
   end

   // ROM data arrives one cycle after the read strobe, i.e. during e_wait.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         send_buf <= '0;
      end else if (state == e_wait) begin
         send_buf <= bp_cfg_entry_s'(rom_data_i);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         done_r <= 1'b0;
      end else if (clear_cnt) begin
         done_r <= 1'b0;
      end else if (state_n == e_done) begin
         done_r <= 1'b1;
      end
   end

   assign cfg_pkt.core = CFG_CORE_WIDTH'(core_cnt);
   assign cfg_pkt.addr = send_buf.addr;
   assign cfg_pkt.data = send_buf.data;

   assign rom_v_o    = (state == e_fetch);
   assign rom_idx_o  = entry_cnt;
   assign cfg_v_o    = (state == e_send);
   assign cfg_core_o = cfg_pkt.core;
   assign cfg_addr_o = cfg_pkt.addr;
   assign cfg_data_o = cfg_pkt.data;
   assign busy_o     = (state == e_fetch) || (state == e_wait) || (state == e_send);
   assign done_o     = done_r;

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_loader.sv
`default_nettype none
// -------------------------------------------------------------------------
// tb_bp_cfg_loader: scoreboard bench for 2x3 and 1x1 loaders.      Rev 1.0
// -------------------------------------------------------------------------
module tb_bp_cfg_loader;

   logic        clk;
   logic        rst;

   logic        start_a, ready_a;
   logic        rom_v_a, cfg_v_a, busy_a, done_a;
   logic [1:0]  rom_idx_a;
   logic [79:0] rom_data_a;
   logic [7:0]  cfg_core_a;
   logic [15:0] cfg_addr_a;
   logic [63:0] cfg_data_a;

   logic        start_e, ready_e;
   logic        rom_v_e, cfg_v_e, busy_e, done_e;
   logic [0:0]  rom_idx_e;
   logic [79:0] rom_data_e;
   logic [7:0]  cfg_core_e;
   logic [15:0] cfg_addr_e;
   logic [63:0] cfg_data_e;

   bp_cfg_loader #(
      .num_core_p (2), .num_entries_p (3),
      .cfg_core_width_p (8), .cfg_addr_width_p (16), .cfg_data_width_p (64)
   ) dut_a (
      .clk_i (clk), .reset_i (rst), .start_i (start_a),
      .rom_v_o (rom_v_a), .rom_idx_o (rom_idx_a), .rom_data_i (rom_data_a),
      .cfg_v_o (cfg_v_a), .cfg_core_o (cfg_core_a), .cfg_addr_o (cfg_addr_a),
      .cfg_data_o (cfg_data_a), .cfg_ready_i (ready_a),
      .busy_o (busy_a), .done_o (done_a)
   );

   bp_cfg_loader #(
      .num_core_p (1), .num_entries_p (1),
      .cfg_core_width_p (8), .cfg_addr_width_p (16), .cfg_data_width_p (64)
   ) dut_e (
      .clk_i (clk), .reset_i (rst), .start_i (start_e),
      .rom_v_o (rom_v_e), .rom_idx_o (rom_idx_e), .rom_data_i (rom_data_e),
      .cfg_v_o (cfg_v_e), .cfg_core_o (cfg_core_e), .cfg_addr_o (cfg_addr_e),
      .cfg_data_o (cfg_data_e), .cfg_ready_i (ready_e),
      .busy_o (busy_e), .done_o (done_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] rom_addr [4];
   logic [63:0] rom_dat  [4];

   always @(posedge clk) begin
      if (rom_v_a) rom_data_a <= {rom_addr[rom_idx_a], rom_dat[rom_idx_a]};
      if (rom_v_e) rom_data_e <= {16'h0055 + 16'(rom_idx_e), 64'h1234};
   end

   typedef struct {
      logic [7:0]  core;
      logic [15:0] addr;
      logic [63:0] data;
   } wr_t;

   typedef struct {
      string name;
      bit    toggle_ready;
      bit    restart_mid;
      int    exp_writes;
      int    exp_done_edge;
   } vec_t;

   wr_t  exp_q [$];
   wr_t  held;
   bit   held_v;
   int   wr_count;
   int   checks;
   int   failures;
   vec_t tbl [3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_exp();
      for (int c = 0; c < 2; c++) begin
         for (int e = 0; e < 3; e++) begin
            wr_t w;
            w.core = 8'(c);
            w.addr = rom_addr[e];
            w.data = rom_dat[e];
            exp_q.push_back(w);
         end
      end
   endtask

   // Called once per cycle at the falling edge, after inputs for the next edge are set.
   task automatic mon_a();
      if (cfg_v_a) begin
         check("no_rom_cfg_overlap", 64'(rom_v_a), 64'(0));
         if (held_v) begin
            check("hold_core", 64'(cfg_core_a), 64'(held.core));
            check("hold_addr", 64'(cfg_addr_a), 64'(held.addr));
            check("hold_data", cfg_data_a, held.data);
         end
         if (ready_a) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got core=%0h addr=%0h, expected no write",
                        cfg_core_a, cfg_addr_a);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_core", 64'(cfg_core_a), 64'(e.core));
               check("wr_addr", 64'(cfg_addr_a), 64'(e.addr));
               check("wr_data", cfg_data_a, e.data);
            end
            wr_count++;
            held_v = 1'b0;
         end else begin
            held.core = cfg_core_a;
            held.addr = cfg_addr_a;
            held.data = cfg_data_a;
            held_v    = 1'b1;
         end
      end
   endtask

   task automatic run_seq(input string name, input bit toggle, input bit restart,
                          input int exp_writes, input int exp_edge);
      int done_seen;
      done_seen = -1;
      push_exp();
      wr_count = 0;
      held_v   = 1'b0;
      @(negedge clk);
      start_a = 1'b1;
      ready_a = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         start_a = restart && (wr_count == 2) && cfg_v_a;
         ready_a = toggle ? ~ready_a : 1'b1;
         mon_a();
         if (k == 1) begin
            check({name, "_busy_after_start"}, 64'(busy_a), 64'(1));
            check({name, "_done_cleared"}, 64'(done_a), 64'(0));
         end
         if (done_a) begin
            done_seen = k - 1;
            break;
         end
      end
      if (exp_edge >= 0) check({name, "_done_edge"}, 64'(done_seen), 64'(exp_edge));
      else               check({name, "_done_reached"}, 64'(done_seen >= 0), 64'(1));
      start_a = 1'b0;
      ready_a = 1'b1;
      repeat (8) begin
         @(negedge clk);
         mon_a();
      end
      check({name, "_write_count"}, 64'(wr_count), 64'(exp_writes));
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
      check({name, "_idle_busy"}, 64'(busy_a), 64'(0));
      check({name, "_done_sticky"}, 64'(done_a), 64'(1));
   endtask

   initial begin
      int  n_e, done_e_edge;
      bit  hit;
      checks   = 0;
      failures = 0;
      rom_addr = '{16'h0010, 16'h0020, 16'h0030, 16'h0000};
      rom_dat  = '{64'hA, 64'hB, 64'hC, 64'h0};
      tbl[0] = '{"A_ready_high",      1'b0, 1'b0, 6, 18};
      tbl[1] = '{"B_ready_toggle",    1'b1, 1'b0, 6, -1};
      tbl[2] = '{"C_restart_ignored", 1'b0, 1'b1, 6, 18};

      rst = 1'b1; start_a = 1'b0; ready_a = 1'b1; start_e = 1'b0; ready_e = 1'b1;
      held_v = 1'b0; wr_count = 0;
      repeat (2) @(posedge clk);
      #3;
      check("rst_rom_v",  64'(rom_v_a), 64'(0));
      check("rst_cfg_v",  64'(cfg_v_a), 64'(0));
      check("rst_busy",   64'(busy_a),  64'(0));
      check("rst_done",   64'(done_a),  64'(0));
      check("rst_addr",   64'(cfg_addr_a), 64'(0));
      check("rst_e_busy", 64'(busy_e),  64'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         run_seq(tbl[i].name, tbl[i].toggle_ready, tbl[i].restart_mid,
                 tbl[i].exp_writes, tbl[i].exp_done_edge);
      end

      // Reset while the fourth write waits for a ready that never comes.
      push_exp();
      wr_count = 0;
      held_v   = 1'b0;
      hit      = 1'b0;
      @(negedge clk);
      start_a = 1'b1;
      ready_a = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         start_a = 1'b0;
         if (wr_count == 3 && cfg_v_a) begin
            ready_a = 1'b0;
            #2 rst = 1'b1;
            #1;
            check("D_cfg_v_reset",  64'(cfg_v_a), 64'(0));
            check("D_busy_reset",   64'(busy_a),  64'(0));
            check("D_rom_v_reset",  64'(rom_v_a), 64'(0));
            check("D_done_reset",   64'(done_a),  64'(0));
            hit = 1'b1;
            break;
         end
         ready_a = 1'b1;
         mon_a();
      end
      check("D_reset_point_reached", 64'(hit), 64'(1));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      held_v = 1'b0;
      check("D_done_after_reset", 64'(done_a), 64'(0));
      run_seq("D_restart", 1'b0, 1'b0, 6, 18);

      // Single core, single entry.
      n_e = 0;
      done_e_edge = -1;
      @(negedge clk);
      start_e = 1'b1;
      ready_e = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start_e = 1'b0;
         if (cfg_v_e && ready_e) begin
            n_e++;
            check("E_core", 64'(cfg_core_e), 64'(0));
            check("E_addr", 64'(cfg_addr_e), 64'h55);
            check("E_data", cfg_data_e, 64'h1234);
            check("E_no_overlap", 64'(rom_v_e), 64'(0));
         end
         if (done_e && done_e_edge < 0) done_e_edge = k - 1;
      end
      check("E_write_count", 64'(n_e), 64'(1));
      check("E_done_edge", 64'(done_e_edge), 64'(3));
      start_e = 1'b1;
      @(negedge clk);
      start_e = 1'b0;
      check("E_done_clears_on_start", 64'(done_e), 64'(0));
      check("E_busy_on_restart", 64'(busy_e), 64'(1));
      repeat (6) @(negedge clk);
      check("E_done_again", 64'(done_e), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
